// File: rtl/fb_spi_pkg.sv
// fb_spi_pkg: opcodes, parser states and STATUS byte layout for the SPI framebuffer writer.
package fb_spi_pkg;
  typedef enum logic [7:0] {
    CMD_WRITE_RGB = 8'h01,
    CMD_WRITE_PAL = 8'h02,
    CMD_READ_RGB  = 8'h03,
    CMD_STATUS    = 8'h04
  } cmd_e;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_PIDX, S_PDATA, S_DISCARD
  } state_e;
  localparam int FRAME_PIXELS_DEFAULT = 76800;
  localparam int STAT_VBLANK = 7;
  localparam int STAT_HBLANK = 6;
  localparam int STAT_ERR    = 0;
  function automatic logic [7:0] status_byte(input logic vb, input logic hb, input logic e);
    logic [7:0] s;
    s = '0;
    s[STAT_VBLANK] = vb;
    s[STAT_HBLANK] = hb;
    s[STAT_ERR]    = e;
    return s;
  endfunction
endpackage

// File: rtl/fb_spi_writer_bit_sync.sv
// bit_sync: multi-flop synchronizer bringing a single flag into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else sh <= STAGES'({sh, d});
  assign q = sh[STAGES-1];
endmodule

// File: rtl/fb_spi_writer.sv
// fb_spi_writer: parses the MCU SPI byte stream into framebuffer/palette accesses and status reads.
module fb_spi_writer
  import fb_spi_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic [16:0] rgb_addr,
  output logic [7:0]  rgb_wdata,
  output logic        wren_rgb,
  input  logic [7:0]  rgb_rdata,
  output logic [7:0]  palette_addr,
  output logic [23:0] palette_wdata,
  output logic        wren_palette,
  input  logic        hblank_async,
  input  logic        vblank_async
);
  localparam logic [16:0] LAST = 17'(FRAME_PIXELS - 1);
  state_e      state;
  logic [1:0]  cnt;
  logic        is_read;
  logic        err;
  logic [16:0] addr;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [1:0]  rd_pipe;
  logic        hblank_s;
  logic        vblank_s;
  logic [16:0] addr_full;
  logic [16:0] addr_inc;
  bit_sync #(.STAGES(SYNC_STAGES)) u_hsync (.clk(clk), .rst_n(rst_n), .d(hblank_async), .q(hblank_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_vsync (.clk(clk), .rst_n(rst_n), .d(vblank_async), .q(vblank_s));
  // Shifting address bytes through 17 bits drops bits [23:17] for free.
  assign addr_full = {addr[8:0], rx_byte};
  assign addr_inc  = (addr == LAST) ? '0 : addr + 17'd1;
  assign rgb_addr  = addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      is_read       <= 1'b0;
      err           <= 1'b0;
      addr          <= '0;
      red           <= '0;
      green         <= '0;
      rd_pipe       <= '0;
      tx_byte       <= '0;
      rgb_wdata     <= '0;
      wren_rgb      <= 1'b0;
      palette_addr  <= '0;
      palette_wdata <= '0;
      wren_palette  <= 1'b0;
    end else begin
      wren_rgb     <= 1'b0;
      wren_palette <= 1'b0;
      // Read pipe: address out, RAM registers, then capture into tx_byte.
      rd_pipe      <= {rd_pipe[0], 1'b0};
      if (rd_pipe[1]) tx_byte <= rgb_rdata;
      if (wren_rgb) addr <= addr_inc;
      if (wren_palette) palette_addr <= palette_addr + 8'd1;
      if (frame_start) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            case (rx_byte)
              CMD_WRITE_RGB: begin state <= S_ADDR; is_read <= 1'b0; end
              CMD_READ_RGB:  begin state <= S_ADDR; is_read <= 1'b1; end
              CMD_WRITE_PAL: state <= S_PIDX;
              CMD_STATUS: begin
                tx_byte <= status_byte(vblank_s, hblank_s, err);
                err     <= 1'b0;
                state   <= S_DISCARD;
              end
              default: begin err <= 1'b1; state <= S_DISCARD; end
            endcase
          end
          S_ADDR: begin
            if (cnt == 2'd2) begin
              addr       <= (addr_full > LAST) ? '0 : addr_full;
              err        <= err | (addr_full > LAST);
              state      <= is_read ? S_RDATA : S_WDATA;
              rd_pipe[0] <= is_read;
              cnt        <= '0;
            end else begin
              addr <= addr_full;
              cnt  <= cnt + 2'd1;
            end
          end
          S_WDATA: begin
            rgb_wdata <= rx_byte;
            wren_rgb  <= 1'b1;
          end
          S_RDATA: begin
            addr       <= addr_inc;
            rd_pipe[0] <= 1'b1;
          end
          S_PIDX: begin
            palette_addr <= rx_byte;
            state        <= S_PDATA;
            cnt          <= '0;
          end
          S_PDATA: begin
            if (cnt == 2'd0) red <= rx_byte;
            if (cnt == 2'd1) green <= rx_byte;
            if (cnt == 2'd2) begin
              palette_wdata <= {red, green, rx_byte};
              wren_palette  <= 1'b1;
            end
            cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
          end
          S_DISCARD: state <= S_DISCARD;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fb_spi_writer.sv
// tb_fb_spi_writer: randomized and directed bench for fb_spi_writer against a byte-stream reference model.
module tb_fb_spi_writer;
  typedef logic [7:0] bq_t[$];
  typedef struct {int a; int d; int c;} wr_t;
  logic        clk = 0, rst_n = 0, frame_start = 0, rx_valid = 0;
  logic        hblank_async = 0, vblank_async = 0;
  logic [7:0]  rx_byte = 0, rgb_rdata = 0;
  logic [7:0]  tx_byte, rgb_wdata, palette_addr;
  logic [16:0] rgb_addr;
  logic [23:0] palette_wdata;
  logic        wren_rgb, wren_palette;
  int          checks = 0, errors = 0, cyc = 0;
  wr_t         rgb_q[$], pal_q[$], exp_q[$];
  int          stb[$];
  logic [7:0]  mem[int];
  logic [7:0]  model_mem[int];

  fb_spi_writer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .rgb_addr(rgb_addr), .rgb_wdata(rgb_wdata),
    .wren_rgb(wren_rgb), .rgb_rdata(rgb_rdata), .palette_addr(palette_addr),
    .palette_wdata(palette_wdata), .wren_palette(wren_palette),
    .hblank_async(hblank_async), .vblank_async(vblank_async)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM with one-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rgb_rdata <= mem.exists(int'(rgb_addr)) ? mem[int'(rgb_addr)] : 8'h00;
    if (wren_rgb) mem[int'(rgb_addr)] = rgb_wdata;
  end

  always @(negedge clk) begin
    if (wren_rgb) rgb_q.push_back('{int'(rgb_addr), int'(rgb_wdata), cyc});
    if (wren_palette) pal_q.push_back('{int'(palette_addr), int'(palette_wdata), cyc});
    if (wren_rgb && wren_palette) begin
      errors++;
      $display("FAIL wren_overlap: both write enables high at cycle %0d, required at most one", cyc);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask
  task automatic pulse_fs(); frame_start = 1; tick(); frame_start = 0; tick(); endtask
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1; stb.push_back(cyc); tick(); rx_valid = 0;
  endtask
  task automatic send_stream(input bq_t b);
    stb.delete();
    pulse_fs();
    foreach (b[i]) begin send_byte(b[i]); idle(4); end
  endtask

  function automatic void model_rgb(input bq_t b);
    int a;
    exp_q.delete();
    if (b.size() < 4 || b[0] != 8'h01) return;
    a = (int'(b[1]) * 65536 + int'(b[2]) * 256 + int'(b[3])) % 131072;
    if (a >= 76800) a = 0;
    for (int i = 4; i < b.size(); i++) begin
      exp_q.push_back('{a, int'(b[i]), stb[i] + 1});
      model_mem[a] = b[i];
      a = (a + 1) % 76800;
    end
  endfunction

  function automatic void model_pal(input bq_t b);
    int idx;
    exp_q.delete();
    if (b.size() < 2 || b[0] != 8'h02) return;
    idx = int'(b[1]);
    for (int i = 2; i + 2 < b.size(); i += 3) begin
      exp_q.push_back('{idx, int'(b[i]) * 65536 + int'(b[i+1]) * 256 + int'(b[i+2]), stb[i+2] + 1});
      idx = (idx + 1) % 256;
    end
  endfunction

  function automatic logic [7:0] model_px(input int a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 0; idle(3);
    checks++;
    if ({tx_byte, rgb_addr, rgb_wdata, wren_rgb, palette_addr, palette_wdata, wren_palette} !== '0) begin
      errors++; $display("FAIL reset_outputs: tx=%h addr=%h wd=%h pa=%h pd=%h, required all 0",
        tx_byte, rgb_addr, rgb_wdata, palette_addr, palette_wdata);
    end
    rst_n = 1; idle(2);
    stb.delete(); pulse_fs(); send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h00) begin
      errors++; $display("FAIL reset_status: tx=%h required 00", tx_byte);
    end
    idle(4);
  endtask

  task automatic test_write_rgb();
    bq_t s;
    int a;
    for (int t = 0; t < 12; t++) begin
      case (t)
        0: s = '{8'h01, 8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB};
        1: s = '{8'h01, 8'h01, 8'h2B, 8'hFF, 8'h11, 8'h22};
        2: s = '{8'h01, 8'hFE, 8'h00, 8'h07, 8'h44};
        3: s = '{8'h01, 8'h01, 8'h2C, 8'h00, 8'h33};
        default: begin
          a = ($urandom_range(0, 1) == 1) ? 76800 - int'($urandom_range(1, 3)) : int'($urandom_range(0, 131071));
          a += 131072 * int'($urandom_range(0, 127));
          s.delete();
          s.push_back(8'h01); s.push_back(8'(a >> 16)); s.push_back(8'(a >> 8)); s.push_back(8'(a));
          repeat ($urandom_range(1, 5)) s.push_back(8'($urandom));
        end
      endcase
      rgb_q.delete(); pal_q.delete();
      send_stream(s);
      model_rgb(s);
      checks++;
      if (rgb_q.size() != exp_q.size() || pal_q.size() != 0) begin
        errors++; $display("FAIL wr%0d_count: rgb writes %0d pal writes %0d, required %0d and 0",
          t, rgb_q.size(), pal_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (rgb_q[i].a != exp_q[i].a || rgb_q[i].d != exp_q[i].d || rgb_q[i].c != exp_q[i].c) begin
          errors++; $display("FAIL wr%0d_px%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
            t, i, rgb_q[i].a, rgb_q[i].d, rgb_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
        end
      end
    end
  endtask

  task automatic test_palette();
    bq_t s;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) s = '{8'h02, 8'hFE, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
      else begin
        s.delete(); s.push_back(8'h02);
        repeat ($urandom_range(1, 11)) s.push_back(8'($urandom));
      end
      rgb_q.delete(); pal_q.delete();
      send_stream(s);
      pulse_fs(); idle(4);
      model_pal(s);
      checks++;
      if (pal_q.size() != exp_q.size() || rgb_q.size() != 0) begin
        errors++; $display("FAIL pal%0d_count: pal writes %0d rgb writes %0d, required %0d and 0",
          t, pal_q.size(), rgb_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        checks++;
        if (pal_q[i].a != exp_q[i].a || pal_q[i].d != exp_q[i].d || pal_q[i].c != exp_q[i].c) begin
          errors++; $display("FAIL pal%0d_e%0d: idx=%h rgb=%h cyc=%0d, required idx=%h rgb=%h cyc=%0d",
            t, i, pal_q[i].a, pal_q[i].d, pal_q[i].c, exp_q[i].a, exp_q[i].d, exp_q[i].c);
        end
      end
    end
  endtask

  task automatic test_read();
    bq_t s;
    int a;
    logic [7:0] prev;
    for (int t = 0; t < 6; t++) begin
      a = (t == 0) ? 9 : (t == 1) ? 76798 : int'($urandom_range(0, 76799));
      if (t == 0) s = '{8'h01, 8'h00, 8'h00, 8'h09, 8'h3C, 8'h5A};
      else begin
        s.delete();
        s.push_back(8'h01); s.push_back(8'(a >> 16)); s.push_back(8'(a >> 8)); s.push_back(8'(a));
        repeat (3) s.push_back(8'($urandom));
      end
      send_stream(s);
      model_rgb(s);
      rgb_q.delete(); pal_q.delete(); stb.delete();
      pulse_fs();
      send_byte(8'h03); idle(4);
      send_byte(8'(a >> 16)); idle(4);
      send_byte(8'(a >> 8)); idle(4);
      for (int k = 0; k < 3; k++) begin
        prev = tx_byte;
        if (k == 0) send_byte(8'(a));
        else begin a = (a + 1) % 76800; send_byte(8'($urandom)); end
        idle(1);
        checks++;
        if (tx_byte !== prev) begin
          errors++; $display("FAIL rd%0d_early%0d: tx=%h two cycles after strobe, required %h", t, k, tx_byte, prev);
        end
        idle(1);
        checks++;
        if (tx_byte !== model_px(a)) begin
          errors++; $display("FAIL rd%0d_px%0d: tx=%h at addr %0d, required %h", t, k, tx_byte, a, model_px(a));
        end
        idle(1);
      end
      checks++;
      if (rgb_q.size() != 0 || pal_q.size() != 0) begin
        errors++; $display("FAIL rd%0d_nowrite: rgb writes %0d pal writes %0d, required 0", t, rgb_q.size(), pal_q.size());
      end
    end
  endtask

  task automatic test_errors();
    bq_t s;
    rgb_q.delete(); pal_q.delete();
    s = '{8'h7F, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEE};
    send_stream(s);
    checks++;
    if (rgb_q.size() != 0) begin
      errors++; $display("FAIL err_discard: %0d writes, required 0", rgb_q.size());
    end
    vblank_async = 1; idle(3);
    pulse_fs(); send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h81) begin
      errors++; $display("FAIL status_err: tx=%h required 81", tx_byte);
    end
    idle(4);
    foreach (s[i]) if (i > 0) begin send_byte(s[i]); idle(4); end
    checks++;
    if (rgb_q.size() != 0) begin
      errors++; $display("FAIL status_tail: %0d writes, required 0", rgb_q.size());
    end
    pulse_fs(); send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h80) begin
      errors++; $display("FAIL status_clear: tx=%h required 80", tx_byte);
    end
    idle(4);
    frame_start = 1; vblank_async = 0; hblank_async = 1; tick(); frame_start = 0;
    send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h80) begin
      errors++; $display("FAIL status_lag: tx=%h required 80", tx_byte);
    end
    idle(4);
    pulse_fs(); send_byte(8'h04);
    checks++;
    if (tx_byte !== 8'h40) begin
      errors++; $display("FAIL status_hblank: tx=%h required 40", tx_byte);
    end
    hblank_async = 0; idle(4);
  endtask

  task automatic test_reset_mid();
    bq_t s;
    rgb_q.delete();
    s = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h11};
    send_stream(s);
    model_rgb(s);
    send_byte(8'h22);
    rst_n = 0; #1;
    checks++;
    if ({tx_byte, rgb_addr, rgb_wdata, wren_rgb, palette_addr, palette_wdata, wren_palette} !== '0) begin
      errors++; $display("FAIL midreset_outputs: tx=%h addr=%h wd=%h wren=%b, required all 0",
        tx_byte, rgb_addr, rgb_wdata, wren_rgb);
    end
    idle(2); rst_n = 1; idle(2);
    send_byte(8'hAA); idle(4);
    send_byte(8'hBB); idle(4);
    checks++;
    if (rgb_q.size() != 1) begin
      errors++; $display("FAIL midreset_count: %0d writes, required 1", rgb_q.size());
    end else begin
      checks++;
      if (rgb_q[0].a != exp_q[0].a || rgb_q[0].d != exp_q[0].d) begin
        errors++; $display("FAIL midreset_px: addr=%0d data=%h, required addr=%0d data=%h",
          rgb_q[0].a, rgb_q[0].d, exp_q[0].a, exp_q[0].d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_rgb();
    test_palette();
    test_read();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_spi_writer.md
# fb_spi_writer

- Parses the SPI byte stream from the MCU and drives the SPI-side ports of the 320×240 indexed framebuffer and its 256-entry palette.
- Handles pixel writes, palette writes and pixel read-back, and reports blanking status.
- Sits between the SPI slave shifter and the framebuffer in the `clk` domain.
- Synchronizes the pixel-domain `hblank`/`vblank` so the MCU can time updates to blanking.

## Interface
Parameters:
- `FRAME_PIXELS`, 76800, number of framebuffer entries; the address wraps to 0 at this value.
- `SYNC_STAGES`, 2, flip-flop depth of the blanking synchronizers.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - `clk` in 1: single clock, also drives the framebuffer `clk_rgb`/`clk_palette`.
  - `rst_n` in 1: asynchronous, active-low reset.
- SPI slave side:
  - `frame_start` in 1: one-cycle pulse on CS assertion; aborts any command and returns to IDLE.
  - `rx_valid` in 1: one-cycle strobe; `rx_byte` is valid. Strobes are ≥4 cycles apart.
  - `rx_byte` in 8: received byte.
  - `tx_byte` out 8: byte the shifter sends in the next SPI byte slot.
- Framebuffer side:
  - `rgb_addr` out 17: framebuffer address.
  - `rgb_wdata` out 8: pixel (palette index) to write.
  - `wren_rgb` out 1: one-cycle write enable.
  - `rgb_rdata` in 8: registered read data, valid 1 cycle after `rgb_addr` with `wren_rgb`=0.
  - `palette_addr` out 8: palette index.
  - `palette_wdata` out 24: {R,G,B} entry to write.
  - `wren_palette` out 1: one-cycle palette write enable.
- Blanking status:
  - `hblank_async` in 1: `clk_pixel`-domain flag.
  - `vblank_async` in 1: `clk_pixel`-domain flag.

## Operation
- First byte after `frame_start` (or after reset) is the command:
  - `0x01` WRITE_RGB: 3 address bytes, big-endian; bits [23:17] are ignored. Each following byte writes one pixel at `addr`, then `addr++`.
  - `0x02` WRITE_PAL: 1 start-index byte, then R,G,B triplets. Each completed triplet writes {R,G,B} at the current index, then the index increments, wrapping 255→0. A partial triplet at `frame_start` is discarded.
  - `0x03` READ_RGB: 3 address bytes. Each following (dummy) byte advances `addr` and reloads `tx_byte` with the pixel at the new address. `tx_byte` holds pixel[addr] once the address is complete.
  - `0x04` STATUS: `tx_byte` = {vblank_s, hblank_s, 5'b0, err}. Reading STATUS clears `err`. Remaining bytes are ignored.
  - Any other command byte: sets sticky `err`, enters DISCARD, and ignores bytes until `frame_start`.
- States: IDLE → ADDR (byte counter 0..2) → WDATA / RDATA; IDLE → PIDX → PDATA (byte counter 0..2); IDLE → DISCARD. A completed STATUS also goes to DISCARD.
- Address arithmetic: `addr == FRAME_PIXELS-1` increments to 0. An address byte sequence ≥ `FRAME_PIXELS` (after the 17-bit truncation) is reduced to `addr` = 0 and sets `err`.
- `frame_start` in the same cycle as `rx_valid`: `frame_start` wins; the byte is dropped.
- `wren_rgb` and `wren_palette` are never high together, and never high during READ_RGB.

## Timing
- Reset values: all outputs 0, state IDLE, `err`=0, synchronizers 0.
- Write: data byte strobe at cycle N → `wren_rgb` high at N+1 with `rgb_addr`/`rgb_wdata` valid; `addr` increments at N+2.
- Palette write: 3rd byte of a triplet at N → `wren_palette` high at N+1.
- Read: last address byte, or a dummy byte, at N → `rgb_addr` updated at N+1, `rgb_rdata` valid at N+2, `tx_byte` loaded at N+3.
- STATUS: command byte at N → `tx_byte` loaded at N+1.
- Blanking flags lag the async inputs by `SYNC_STAGES` cycles.
- Reset asserted mid-command: immediate return to reset values. No write strobe is emitted after `rst_n` falls.

## Structure
- Package `fb_spi_pkg`:
  - `cmd_e` with the four opcodes.
  - `state_e`.
  - `FRAME_PIXELS_DEFAULT` = 76800.
  - Status bit positions.
- Sub-module `bit_sync` (parameterized depth, async active-low reset): one instance per blanking flag.

## Test plan
- WRITE_RGB: `01 00 00 05 AA BB` → `wren_rgb` pulses at addr 5 (data AA) and addr 6 (data BB), each 1 cycle after its strobe.
- Wrap: `01 01 2B FF 11 22` → writes to 76799 then 0.
- WRITE_PAL: `02 FE 10 20 30 40 50 60 70` → 0xFE={102030}, 0xFF={405060}; `70` produces no write, and a following `frame_start` discards it.
- READ_RGB: model memory with pixel[9]=0x3C, pixel[10]=0x5A; send `03 00 00 09` then a dummy byte → `tx_byte` = 3C, then 5A 3 cycles after the dummy strobe.
- Errors: command byte `7F` then `01 00 00 00 EE` without `frame_start` → no writes. Then `frame_start`, `04` with vblank_async=1 held → `tx_byte`=0x81; a second STATUS → 0x80.
- Reset asserted between two pixel bytes → all outputs 0. After release, a data byte without a command produces no write.
